// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_pkg
//  Purpose  : Shared constants for the decoder_seq block: the encoding of the
//             two-bit mode input that selects how the registered index moves.
//  Contents : MODE_DIRECT  - index follows sel on every enabled edge
//             MODE_STEP_UP - index increments on each step pulse
//             MODE_STEP_DN - index decrements on each step pulse
//             MODE_AUTO    - index increments every PERIOD enabled cycles
//  Revision : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    localparam logic [1:0] MODE_DIRECT  = 2'b00;
    localparam logic [1:0] MODE_STEP_UP = 2'b01;
    localparam logic [1:0] MODE_STEP_DN = 2'b10;
    localparam logic [1:0] MODE_AUTO    = 2'b11;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decoder_onehot.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_onehot
//  Purpose  : Purely combinational N-to-2**N one-hot decoder with an enable.
//             Each output is the AND of the enable and a full match of the
//             index, i.e. the textbook gate-level enable decoder widened to
//             any N. Always active-high; polarity is applied by the parent.
//  Ports    : i_idx [N-1:0]     index to decode
//             i_en              enable; all outputs low when deasserted
//             o_y   [2**N-1:0]  one-hot decoded lines
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_onehot
    import decoder_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]    i_idx,
    input  logic            i_en,
    output logic [2**N-1:0] o_y
);

    genvar i;
    generate
        for (i = 0; i < 2**N; i++) begin : g_line
            assign o_y[i] = i_en & (i_idx == N'(i));
        end
    endgenerate

endmodule : decoder_onehot
`default_nettype wire

// File: rtl/decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_seq
//  Purpose  : Parametrised N-to-2**N decoder with a registered index and a
//             built-in sequencer. The index is loaded directly, stepped up or
//             down by pulses, or auto-scanned at a fixed cycle period. The
//             decoded output depends on registered state only, so there is
//             no combinational path from any input to y.
//  Params   : N          select width; OUT_W = 2**N output lines
//             ACTIVE_LOW 1 = selected line low, disabled pattern all ones
//             PERIOD     enabled clk cycles per advance in auto mode (>= 1)
//  Ports    : clk         rising-edge clock
//             rst_n       asynchronous active-low reset
//             en          enable (registered); low holds index and prescaler
//             mode  [1:0] 00 direct, 01 step-up, 10 step-down, 11 auto-up
//             sel   [N-1:0] value for direct mode and for load
//             load        pulse: index <= sel, overrides the mode action
//             step        pulse: advance by one in the step modes
//             y     [OUT_W-1:0] decoded (one-hot or one-cold) lines
//             idx   [N-1:0] current registered index
//             wrap        one-cycle pulse on a modulo wrap of the index
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int N          = 2,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter int PERIOD     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [N-1:0]      sel,
    input  logic              load,
    input  logic              step,
    output logic [2**N-1:0]   y,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int OUT_W = 2**N;

    // A one-bit prescaler is kept even for PERIOD=1 so the compare below is
    // always well formed; with PERIOD=1 it simply never leaves zero.
    localparam int               c_pscW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [c_pscW-1:0] c_pscLast = c_pscW'(PERIOD - 1);
    localparam logic [N-1:0]     c_idxMax  = {N{1'b1}};
    localparam logic [N-1:0]     c_idxOne  = N'(1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [N-1:0]      r_idx;
    logic              r_enR;
    logic [c_pscW-1:0] r_psc;
    logic              r_wrap;
    logic [1:0]        r_prevMode;

    // ------------------------------------------------------------------
    // Next-state logic, applied only on enabled edges
    // ------------------------------------------------------------------
    logic [N-1:0]      w_idxNext;
    logic [c_pscW-1:0] w_pscNext;
    logic              w_wrapNext;
    logic              w_modeChg;

    assign w_modeChg = (mode != r_prevMode);

    always_comb begin
        w_idxNext  = r_idx;
        w_pscNext  = '0;
        w_wrapNext = 1'b0;

        if (load) begin
            // Load has priority over every mode action and never wraps.
            w_idxNext = sel;
        end else begin
            case (mode)
                MODE_DIRECT: begin
                    w_idxNext = sel;
                end
                MODE_STEP_UP: begin
                    if (step) begin
                        w_idxNext  = r_idx + c_idxOne;
                        w_wrapNext = (r_idx == c_idxMax);
                    end
                end
                MODE_STEP_DN: begin
                    if (step) begin
                        w_idxNext  = r_idx - c_idxOne;
                        w_wrapNext = (r_idx == '0);
                    end
                end
                MODE_AUTO: begin
                    // The edge that enters auto mode only restarts the
                    // prescaler, so the first advance lands PERIOD enabled
                    // cycles later and every PERIOD cycles thereafter.
                    if (w_modeChg) begin
                        w_pscNext = '0;
                    end else if (r_psc == c_pscLast) begin
                        w_pscNext  = '0;
                        w_idxNext  = r_idx + c_idxOne;
                        w_wrapNext = (r_idx == c_idxMax);
                    end else begin
                        w_pscNext = r_psc + c_pscW'(1);
                    end
                end
                default: begin
                    w_idxNext = r_idx;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_enR      <= 1'b0;
            r_psc      <= '0;
            r_wrap     <= 1'b0;
            r_prevMode <= MODE_DIRECT;
        end else begin
            r_enR <= en;
            if (en) begin
                r_idx      <= w_idxNext;
                r_psc      <= w_pscNext;
                r_wrap     <= w_wrapNext;
                r_prevMode <= mode;
            end else begin
                // Disabled: index, prescaler and mode history are frozen.
                r_wrap <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode and polarity
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] w_hot;

    decoder_onehot #(
        .N (N)
    ) u_onehot (
        .i_idx (r_idx),
        .i_en  (r_enR),
        .o_y   (w_hot)
    );

    generate
        if (ACTIVE_LOW) begin : g_activeLow
            assign y = ~w_hot;
        end else begin : g_activeHigh
            assign y = w_hot;
        end
    endgenerate

    assign idx  = r_idx;
    assign wrap = r_wrap;

endmodule : decoder_seq
`default_nettype wire

// File: tb/tb_decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_seq
//  Purpose  : Self-checking bench for decoder_seq. Three instances share one
//             stimulus stream:
//               d0: N=2, active-high, PERIOD=4
//               d1: N=2, active-low,  PERIOD=4
//               d2: N=3, active-high, PERIOD=1
//             A behavioural model tracks each instance's index, enable,
//             wrap and auto-mode cycle count with plain integer arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_seq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic       step;
    logic [1:0] sel0;
    logic [2:0] sel2;

    logic [3:0] y0, y1;
    logic [7:0] y2;
    logic [1:0] idx0, idx1;
    logic [2:0] idx2;
    logic       wrap0, wrap1, wrap2;

    int vectors;
    int miscompares;

    decoder_seq #(.N(2), .ACTIVE_LOW(1'b0), .PERIOD(4)) d0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel0),
        .load(load), .step(step), .y(y0), .idx(idx0), .wrap(wrap0)
    );
    decoder_seq #(.N(2), .ACTIVE_LOW(1'b1), .PERIOD(4)) d1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel0),
        .load(load), .step(step), .y(y1), .idx(idx1), .wrap(wrap1)
    );
    decoder_seq #(.N(3), .ACTIVE_LOW(1'b0), .PERIOD(1)) d2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel2),
        .load(load), .step(step), .y(y2), .idx(idx2), .wrap(wrap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int n;
        int period;
        bit al;
        int idx;
        bit enR;
        bit wrap;
        int cnt;       // enabled auto-mode cycles since the last restart
        int lastMode;  // mode seen on the previous enabled edge
    } mdl_t;

    mdl_t m[3];

    function automatic mdl_t mReset(mdl_t s);
        mdl_t r = s;
        r.idx = 0; r.enR = 1'b0; r.wrap = 1'b0; r.cnt = 0; r.lastMode = 0;
        return r;
    endfunction

    function automatic mdl_t mAdv(mdl_t s, bit e, int md, bit ld, bit st, int sv);
        mdl_t r = s;
        int size = 1 << s.n;
        r.enR  = e;
        r.wrap = 1'b0;
        if (!e) return r;
        r.cnt = 0;
        if (ld) begin
            r.idx = sv % size;
        end else if (md == 0) begin
            r.idx = sv % size;
        end else if (md == 1) begin
            if (st) begin
                r.wrap = (s.idx == size - 1);
                r.idx  = (s.idx + 1) % size;
            end
        end else if (md == 2) begin
            if (st) begin
                r.wrap = (s.idx == 0);
                r.idx  = (s.idx + size - 1) % size;
            end
        end else begin
            if (md == s.lastMode) begin
                r.cnt = s.cnt + 1;
                if (r.cnt == s.period) begin
                    r.cnt  = 0;
                    r.wrap = (s.idx == size - 1);
                    r.idx  = (s.idx + 1) % size;
                end
            end
        end
        r.lastMode = md;
        return r;
    endfunction

    function automatic logic [7:0] expY(mdl_t s);
        int size = 1 << s.n;
        int v    = s.enR ? (1 << s.idx) : 0;
        if (s.al) v = (~v) & ((1 << size) - 1);
        return 8'(v);
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        check("d0.y",    8'(y0),    expY(m[0]));
        check("d0.idx",  8'(idx0),  8'(m[0].idx));
        check("d0.wrap", 8'(wrap0), 8'(m[0].wrap));
        check("d1.y",    8'(y1),    expY(m[1]));
        check("d1.idx",  8'(idx1),  8'(m[1].idx));
        check("d1.wrap", 8'(wrap1), 8'(m[1].wrap));
        check("d2.y",    y2,        expY(m[2]));
        check("d2.idx",  8'(idx2),  8'(m[2].idx));
        check("d2.wrap", 8'(wrap2), 8'(m[2].wrap));
    endtask

    // One clock edge: model follows the inputs sampled at the edge, then
    // all outputs are compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) m[i] = mReset(m[i]);
        end else begin
            m[0] = mAdv(m[0], en, int'(mode), load, step, int'(sel0));
            m[1] = mAdv(m[1], en, int'(mode), load, step, int'(sel0));
            m[2] = mAdv(m[2], en, int'(mode), load, step, int'(sel2));
        end
        #1;
        checkAll();
    endtask

    task automatic setSel(input int v);
        sel0 = 2'(v);
        sel2 = 3'(v);
    endtask

    // Assert reset between edges and check it takes effect without a clock.
    task automatic asyncReset();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) m[i] = mReset(m[i]);
        check("arst.y0",   8'(y0),    8'h00);
        check("arst.y1",   8'(y1),    8'h0F);
        check("arst.idx0", 8'(idx0),  8'h00);
        check("arst.wrap", 8'(wrap0), 8'h00);
        checkAll();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed and randomized stimulus
    // ------------------------------------------------------------------
    initial begin
        int expIdx[4];
        int expWrap[4];
        logic [7:0] e;

        vectors     = 0;
        miscompares = 0;
        m[0] = '{n: 2, period: 4, al: 1'b0, idx: 0, enR: 1'b0, wrap: 1'b0, cnt: 0, lastMode: 0};
        m[1] = '{n: 2, period: 4, al: 1'b1, idx: 0, enR: 1'b0, wrap: 1'b0, cnt: 0, lastMode: 0};
        m[2] = '{n: 3, period: 1, al: 1'b0, idx: 0, enR: 1'b0, wrap: 1'b0, cnt: 0, lastMode: 0};

        rst_n = 1'b0; en = 1'b0; mode = 2'b00; load = 1'b0; step = 1'b0;
        setSel(0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst.y0",   8'(y0),    8'h00);
        check("rst.y1",   8'(y1),    8'h0F);
        check("rst.idx0", 8'(idx0),  8'h00);
        check("rst.wrap", 8'(wrap0), 8'h00);

        // Direct mode walk
        en = 1'b1; mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            setSel(i);
            cycle();
            e = 8'd1 << i;
            check("direct.y0", 8'(y0), e);
        end
        en = 1'b0;
        cycle();
        check("dis.y0",   8'(y0),   8'h00);
        check("dis.idx0", 8'(idx0), 8'h03);

        // Async reset while running
        en = 1'b1; setSel(3);
        cycle();
        check("pre_rst.y0", 8'(y0), 8'h08);
        asyncReset();

        // Step-up from 2 across the wrap
        en = 1'b1; mode = 2'b00; setSel(2);
        cycle();
        mode = 2'b01; step = 1'b1;
        expIdx  = '{3, 0, 1, 2};
        expWrap = '{0, 1, 0, 0};
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("up.idx0",  8'(idx0),  8'(expIdx[i]));
            check("up.wrap0", 8'(wrap0), 8'(expWrap[i]));
        end

        // Step-down from 0
        mode = 2'b00; step = 1'b0; setSel(0);
        cycle();
        mode = 2'b10; step = 1'b1;
        cycle();
        check("dn.idx0",  8'(idx0),  8'h03);
        check("dn.wrap0", 8'(wrap0), 8'h01);

        // Load beats step at idx 3
        mode = 2'b01; load = 1'b1; step = 1'b1; setSel(1);
        cycle();
        check("ldstep.idx0",  8'(idx0),  8'h01);
        check("ldstep.wrap0", 8'(wrap0), 8'h00);
        load = 1'b0; step = 1'b0;

        // Auto mode, PERIOD=4, with a 3-cycle enable gap
        mode = 2'b00; setSel(0);
        cycle();
        mode = 2'b11;
        for (int c = 1; c <= 20; c++) begin
            en = !(c >= 11 && c <= 13);
            cycle();
            if (c <= 4)       check("auto.idx0", 8'(idx0), 8'h00);
            else if (c <= 8)  check("auto.idx0", 8'(idx0), 8'h01);
            else if (c <= 15) check("auto.idx0", 8'(idx0), 8'h02);
            else if (c <= 19) check("auto.idx0", 8'(idx0), 8'h03);
            else begin
                check("auto.idx0",  8'(idx0),  8'h00);
                check("auto.wrap0", 8'(wrap0), 8'h01);
            end
        end
        en = 1'b1;

        // N=3, PERIOD=1 scan
        load = 1'b1; setSel(0);
        cycle();
        load = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            e = 8'd1 << (k % 8);
            check("scan.y2",    y2,        e);
            check("scan.wrap2", 8'(wrap2), 8'(k == 8));
        end

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(7) == 0) mode = 2'($urandom_range(3));
            en   = ($urandom_range(7) != 0);
            load = ($urandom_range(9) == 0);
            step = 1'($urandom_range(1));
            setSel(int'($urandom_range(7)));
            cycle();
            if ($urandom_range(99) == 0) asyncReset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_decoder_seq
`default_nettype wire

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised N-to-2^N one-hot decoder with registered select state and a built-in sequencer.
- Drives one-hot selects (row/bank/channel enables, LED scan lines) either directly from a select input or by stepping/auto-scanning through outputs.
- Generalises the 2-to-4 enable decoder in width and output polarity, and adds step, reverse and timed auto-scan modes with wrap indication.

Parameters:
- N, 2, select width; output width is 2**N (derived localparam OUT_W).
- ACTIVE_LOW, 0, 1 = outputs active-low: selected line 0, all others 1, disabled state all-ones.
- PERIOD, 4, clk cycles per advance in auto-scan mode; legal range >= 1.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  enable; registered; when low the outputs are disabled, index is held and the prescaler is frozen.
- mode  input  2  00 direct, 01 step-up, 10 step-down, 11 auto-up.
- sel  input  N  select value for direct mode and for load.
- load  input  1  pulse: idx <= sel, in any mode.
- step  input  1  pulse: advance by one in step modes.
- y  output  2**N  one-hot (or one-cold) decoded outputs.
- idx  output  N  current registered index.
- wrap  output  1  one-cycle pulse on modulo wrap.

Behaviour:
- Reset (async, rst_n=0): idx=0, en_r=0, prescaler=0, wrap=0; y=all-0 (ACTIVE_LOW=0) or all-1 (ACTIVE_LOW=1). Release is synchronous to the next clk edge.
- en_r <= en every edge. y is a pure function of registered state only: y = en_r ? onehot(idx) : disabled pattern, inverted when ACTIVE_LOW. There is no combinational path from inputs to y.
- Latency: an input sampled at edge k is visible on y/idx after edge k.
- Priority per edge, evaluated only when en=1: load > mode action. With en=0: nothing updates except en_r; wrap=0.
- direct (00): idx <= sel every enabled edge; wrap stays 0.
- step-up (01): step=1 -> idx <= idx+1 mod 2**N; idx=2**N-1 -> 0 sets wrap=1 for one cycle.
- step-down (10): step=1 -> idx <= idx-1 mod 2**N; idx=0 -> 2**N-1 sets wrap=1.
- auto-up (11): prescaler counts 0..PERIOD-1. On reaching PERIOD-1, idx advances as step-up (with wrap) and the prescaler returns to 0. step is ignored.
- Prescaler clears to 0 on load, on any mode change (mode differs from the registered previous mode), and in non-auto modes. The first auto advance therefore comes PERIOD enabled cycles after entering mode 11.
- load and step in the same cycle: load wins; no advance and no wrap.
- wrap is registered; it is 0 on any cycle without a wrapping advance.
- Prescaler width is $clog2(PERIOD) with a minimum of 1. PERIOD=1 advances every enabled cycle.
- N=1 is legal: 2 outputs, idx toggles.

Decomposition:
- Package decoder_pkg: mode constants MODE_DIRECT=2'b00, MODE_STEP_UP=2'b01, MODE_STEP_DN=2'b10, MODE_AUTO=2'b11.
- Sub-module decoder_onehot (parameter N): purely combinational idx + enable -> 2**N one-hot, gate-level-equivalent generalisation. decoder_seq instantiates it and applies polarity.
- Sequencer and prescaler logic stay in decoder_seq.

Test Plan:
- Reset with N=2, ACTIVE_LOW=0: rst_n=0 mid-run -> y=4'b0000, idx=0, wrap=0 immediately (async). Repeat with ACTIVE_LOW=1 -> y=4'b1111.
- Direct, en=1, sel=0,1,2,3 on consecutive cycles -> y=0001,0010,0100,1000 one edge later. Drop en -> y=0000 next edge with idx held.
- Step-up from idx=2, four step pulses -> idx 3,0,1,2. wrap=1 only on the 3->0 edge. Step-down from 0, one pulse -> idx=3, wrap=1.
- load=1, sel=1 with step=1 in mode 01 at idx=3 -> idx=1, wrap=0.
- Auto mode, PERIOD=4, idx=0: enter mode 11 -> idx=1 after 4 enabled cycles, then every 4. en low for 3 cycles mid-count extends the interval by exactly 3. Wrap pulses on 3->0.
- N=3, PERIOD=1, auto -> idx 0..7 each cycle, y walks 8'h01..8'h80, wrap every 8th cycle.
